// File: rtl/asg_sweep_ctrl.sv
// Frequency-sweep sequencer for one ASG channel: ramps the 64-bit phase step
// from a start to a stop value with a per-step dwell, in single, repeat or ping-pong mode.
module asg_sweep_ctrl #(
    parameter int STW = 64,
    parameter int DWW = 32
) (
    input  logic           dac_clk_i,
    input  logic           dac_rst_i,
    input  logic           cfg_en_i,
    input  logic [STW-1:0] cfg_start_step_i,
    input  logic [STW-1:0] cfg_stop_step_i,
    input  logic [STW-1:0] cfg_inc_i,
    input  logic [DWW-1:0] cfg_dwell_i,
    input  logic [1:0]     cfg_mode_i,
    input  logic [15:0]    cfg_nsweep_i,
    input  logic           start_i,
    input  logic           stop_i,
    output logic [STW-1:0] step_o,
    output logic           step_upd_o,
    output logic           sweep_done_o,
    output logic           busy_o,
    output logic [1:0]     state_o,
    output logic [15:0]    sweep_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state;
    logic [STW-1:0] origin_q;
    logic [STW-1:0] target_q;
    logic [STW-1:0] inc_q;
    logic [DWW-1:0] dwell_q;
    logic [DWW-1:0] dwell_cnt;
    logic [1:0]     mode_q;
    logic [15:0]    nsweep_q;
    logic           up_q;

    logic [STW-1:0] next_step;
    logic [STW-1:0] turn_step;
    logic [15:0]    cnt_inc;
    logic [DWW-1:0] dwell_eff;
    logic           abort;
    logic           at_target;
    logic           last_sweep;

    // One increment toward tgt, computed one bit wider so a carry or borrow
    // out of the step range clamps to the target instead of wrapping.
    function automatic logic [STW-1:0] advance(input logic [STW-1:0] cur,
                                                input logic [STW-1:0] inc,
                                                input logic [STW-1:0] tgt,
                                                input logic           up);
        logic [STW:0] nxt;
        if (up) begin
            nxt = {1'b0, cur} + {1'b0, inc};
            advance = (nxt[STW] || nxt[STW-1:0] > tgt) ? tgt : nxt[STW-1:0];
        end else begin
            nxt = {1'b0, cur} - {1'b0, inc};
            advance = (nxt[STW] || nxt[STW-1:0] < tgt) ? tgt : nxt[STW-1:0];
        end
    endfunction

    always_comb begin
        next_step  = advance(step_o, inc_q, target_q, up_q);
        turn_step  = advance(step_o, inc_q, origin_q, !up_q);
        cnt_inc    = (sweep_cnt_o == 16'hFFFF) ? sweep_cnt_o : sweep_cnt_o + 16'd1;
        dwell_eff  = (cfg_dwell_i == '0) ? {{(DWW-1){1'b0}}, 1'b1} : cfg_dwell_i;
        abort      = stop_i || !cfg_en_i;
        at_target  = (step_o == target_q);
        last_sweep = (nsweep_q != 16'd0) && (cnt_inc == nsweep_q);
    end

    assign state_o = state;

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state        <= S_IDLE;
            step_o       <= '0;
            step_upd_o   <= 1'b0;
            sweep_done_o <= 1'b0;
            busy_o       <= 1'b0;
            sweep_cnt_o  <= '0;
            dwell_cnt    <= '0;
            up_q         <= 1'b1;
            origin_q     <= '0;
            target_q     <= '0;
            inc_q        <= '0;
            dwell_q      <= '0;
            mode_q       <= '0;
            nsweep_q     <= '0;
        end else begin
            step_upd_o   <= 1'b0;
            sweep_done_o <= 1'b0;
            if (abort) begin
                state  <= S_IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start_i) begin
                            state       <= S_RUN;
                            busy_o      <= 1'b1;
                            origin_q    <= cfg_start_step_i;
                            target_q    <= cfg_stop_step_i;
                            inc_q       <= cfg_inc_i;
                            dwell_q     <= dwell_eff;
                            mode_q      <= cfg_mode_i;
                            nsweep_q    <= cfg_nsweep_i;
                            up_q        <= (cfg_start_step_i <= cfg_stop_step_i);
                            step_o      <= cfg_start_step_i;
                            step_upd_o  <= 1'b1;
                            dwell_cnt   <= dwell_eff;
                            sweep_cnt_o <= '0;
                        end
                    end
                    S_RUN: begin
                        if (dwell_cnt > {{(DWW-1){1'b0}}, 1'b1}) begin
                            dwell_cnt <= dwell_cnt - 1'b1;
                        end else if (!at_target) begin
                            step_o     <= next_step;
                            step_upd_o <= 1'b1;
                            dwell_cnt  <= dwell_q;
                        end else begin
                            sweep_done_o <= 1'b1;
                            sweep_cnt_o  <= cnt_inc;
                            if ((mode_q != 2'd1 && mode_q != 2'd2) || last_sweep) begin
                                state  <= S_DONE;
                                busy_o <= 1'b0;
                            end else if (mode_q == 2'd1) begin
                                step_o     <= origin_q;
                                step_upd_o <= 1'b1;
                                dwell_cnt  <= dwell_q;
                            end else begin
                                // Ping-pong: the old origin becomes the target.
                                origin_q   <= target_q;
                                target_q   <= origin_q;
                                up_q       <= !up_q;
                                step_o     <= turn_step;
                                step_upd_o <= 1'b1;
                                dwell_cnt  <= dwell_q;
                            end
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_asg_sweep_ctrl.sv
// Directed bench for asg_sweep_ctrl: a per-sweep schedule model feeds an expected
// queue checked every cycle, plus hand-computed spot checks of key values.
module tb_asg_sweep_ctrl;

    logic        dac_clk_i = 1'b0;
    logic        dac_rst_i = 1'b1;
    logic        cfg_en_i = 1'b1;
    logic [63:0] cfg_start_step_i = '0;
    logic [63:0] cfg_stop_step_i = '0;
    logic [63:0] cfg_inc_i = '0;
    logic [31:0] cfg_dwell_i = '0;
    logic [1:0]  cfg_mode_i = '0;
    logic [15:0] cfg_nsweep_i = '0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [63:0] step_o;
    logic        step_upd_o;
    logic        sweep_done_o;
    logic        busy_o;
    logic [1:0]  state_o;
    logic [15:0] sweep_cnt_o;

    asg_sweep_ctrl dut (
        .dac_clk_i        (dac_clk_i),
        .dac_rst_i        (dac_rst_i),
        .cfg_en_i         (cfg_en_i),
        .cfg_start_step_i (cfg_start_step_i),
        .cfg_stop_step_i  (cfg_stop_step_i),
        .cfg_inc_i        (cfg_inc_i),
        .cfg_dwell_i      (cfg_dwell_i),
        .cfg_mode_i       (cfg_mode_i),
        .cfg_nsweep_i     (cfg_nsweep_i),
        .start_i          (start_i),
        .stop_i           (stop_i),
        .step_o           (step_o),
        .step_upd_o       (step_upd_o),
        .sweep_done_o     (sweep_done_o),
        .busy_o           (busy_o),
        .state_o          (state_o),
        .sweep_cnt_o      (sweep_cnt_o)
    );

    // ---------------- clock / reset ----------------
    always #5 dac_clk_i = ~dac_clk_i;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] step;
        logic        upd;
        logic        done;
        logic [15:0] cnt;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    exp_t hold;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    task automatic clear_hold();
        hold = '{step: 64'd0, upd: 1'b0, done: 1'b0, cnt: 16'd0, st: 2'd0};
    endtask

    always @(negedge dac_clk_i) begin
        if (cmp_en) begin
            exp_t e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = hold;
            hold = e;
            hold.upd = 1'b0;
            hold.done = 1'b0;
            chk("step_o", step_o, e.step);
            chk("step_upd_o", {63'd0, step_upd_o}, {63'd0, e.upd});
            chk("sweep_done_o", {63'd0, sweep_done_o}, {63'd0, e.done});
            chk("sweep_cnt_o", {48'd0, sweep_cnt_o}, {48'd0, e.cnt});
            chk("state_o", {62'd0, state_o}, {62'd0, e.st});
            chk("busy_o", {63'd0, busy_o}, {63'd0, (e.st == 2'd1)});
        end
    end

    // Per-cycle expectation of a whole sweep program: each point occupies
    // max(dwell,1) cycles; a sweep-end cycle carries the done pulse.
    task automatic build_schedule();
        logic [63:0] cur, tgt, org, tmp;
        logic [31:0] d;
        logic [15:0] cnt;
        bit          up, pend_done;
        d = (cfg_dwell_i == 0) ? 32'd1 : cfg_dwell_i;
        cur = cfg_start_step_i;
        org = cfg_start_step_i;
        tgt = cfg_stop_step_i;
        up = (cfg_start_step_i <= cfg_stop_step_i);
        cnt = 16'd0;
        pend_done = 1'b0;
        while (exp_q.size() < 400) begin
            for (int k = 0; k < int'(d); k++)
                exp_q.push_back('{step: cur, upd: (k == 0), done: (k == 0) && pend_done,
                                  cnt: cnt, st: 2'd1});
            pend_done = 1'b0;
            if (cur != tgt) begin
                if (up) cur = (tgt - cur <= cfg_inc_i) ? tgt : cur + cfg_inc_i;
                else    cur = (cur - tgt <= cfg_inc_i) ? tgt : cur - cfg_inc_i;
            end else begin
                if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
                if ((cfg_mode_i != 2'd1 && cfg_mode_i != 2'd2) ||
                    (cfg_nsweep_i != 0 && cnt == cfg_nsweep_i)) begin
                    exp_q.push_back('{step: cur, upd: 1'b0, done: 1'b1, cnt: cnt, st: 2'd2});
                    break;
                end
                pend_done = 1'b1;
                if (cfg_mode_i == 2'd1) begin
                    cur = org;
                end else begin
                    tmp = org; org = tgt; tgt = tmp;
                    up = !up;
                    if (up) cur = (tgt - cur <= cfg_inc_i) ? tgt : cur + cfg_inc_i;
                    else    cur = (cur - tgt <= cfg_inc_i) ? tgt : cur - cfg_inc_i;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input logic [63:0] s, input logic [63:0] e, input logic [63:0] inc,
                           input logic [31:0] dw, input logic [1:0] md, input logic [15:0] ns);
        cfg_start_step_i = s;
        cfg_stop_step_i = e;
        cfg_inc_i = inc;
        cfg_dwell_i = dw;
        cfg_mode_i = md;
        cfg_nsweep_i = ns;
    endtask

    task automatic pulse_start();
        @(posedge dac_clk_i); #1;
        start_i = 1'b1;
        @(posedge dac_clk_i); #1;
        start_i = 1'b0;
        exp_q.delete();
        build_schedule();
    endtask

    // Abort by stop_i (use_en=0) or by dropping cfg_en_i (use_en=1).
    task automatic abort(input bit use_en, input bit with_start);
        @(posedge dac_clk_i); #1;
        if (use_en) cfg_en_i = 1'b0;
        else stop_i = 1'b1;
        start_i = with_start;
        @(posedge dac_clk_i); #1;
        cfg_en_i = 1'b1;
        stop_i = 1'b0;
        start_i = 1'b0;
        exp_q.delete();
        hold.st = 2'd0;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge dac_clk_i);
    endtask

    // ---------------- directed tests ----------------
    logic [63:0] pp_seq [7];

    initial begin
        clear_hold();
        repeat (3) @(posedge dac_clk_i);
        #1 dac_rst_i = 1'b0;
        cmp_en = 1'b1;
        wait_neg(1);
        chk("reset step_o", step_o, 64'd0);
        chk("reset state_o", {62'd0, state_o}, 64'd0);
        chk("reset cnt", {48'd0, sweep_cnt_o}, 64'd0);

        // Up sweep, dwell 4, single
        set_cfg(64'd100, 64'd130, 64'd10, 32'd4, 2'd0, 16'd0);
        pulse_start();
        wait_neg(1);  chk("up first", step_o, 64'd100);
        chk("up first upd", {63'd0, step_upd_o}, 64'd1);
        wait_neg(4);  chk("up +5", step_o, 64'd110);
        wait_neg(4);  chk("up +9", step_o, 64'd120);
        wait_neg(4);  chk("up +13", step_o, 64'd130);
        wait_neg(4);  chk("up done pulse", {63'd0, sweep_done_o}, 64'd1);
        chk("up done state", {62'd0, state_o}, 64'd2);
        wait_neg(3);

        // Down sweep with clamp, restarted from DONE
        set_cfg(64'd50, 64'd5, 64'd20, 32'd1, 2'd0, 16'd0);
        pulse_start();
        wait_neg(1); chk("down 0", step_o, 64'd50);
        wait_neg(1); chk("down 1", step_o, 64'd30);
        wait_neg(1); chk("down 2", step_o, 64'd10);
        wait_neg(1); chk("down 3", step_o, 64'd5);
        wait_neg(1); chk("down done", {63'd0, sweep_done_o}, 64'd1);
        wait_neg(2);

        // Ping-pong, 3 sweeps; later config changes must be ignored
        set_cfg(64'd0, 64'd2, 64'd1, 32'd1, 2'd2, 16'd3);
        pp_seq = '{64'd0, 64'd1, 64'd2, 64'd1, 64'd0, 64'd1, 64'd2};
        pulse_start();
        set_cfg(64'd9, 64'd99, 64'd5, 32'd7, 2'd0, 16'd1);
        for (int i = 0; i < 7; i++) begin
            wait_neg(1);
            chk("pingpong seq", step_o, pp_seq[i]);
        end
        wait_neg(1);
        chk("pingpong cnt", {48'd0, sweep_cnt_o}, 64'd3);
        chk("pingpong done state", {62'd0, state_o}, 64'd2);
        wait_neg(2);

        // Repeat forever, dwell 2, then stop
        set_cfg(64'd0, 64'd1, 64'd1, 32'd2, 2'd1, 16'd0);
        pulse_start();
        wait_neg(20);
        chk("repeat cycle 20", step_o, 64'd1);
        abort(1'b0, 1'b0);
        wait_neg(1);
        chk("repeat stop state", {62'd0, state_o}, 64'd0);
        chk("repeat stop step", step_o, 64'd0);
        chk("repeat stop cnt", {48'd0, sweep_cnt_o}, 64'd5);

        // Near-overflow clamp
        set_cfg(64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h20, 32'd1, 2'd0, 16'd0);
        pulse_start();
        wait_neg(2);
        chk("overflow clamp", step_o, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_neg(3);

        // start and stop together: stop wins
        abort(1'b0, 1'b1);
        wait_neg(2);
        chk("start+stop idle", {62'd0, state_o}, 64'd0);

        // dwell 0 acts as dwell 1
        set_cfg(64'd10, 64'd12, 64'd1, 32'd0, 2'd0, 16'd0);
        pulse_start();
        wait_neg(2);
        chk("dwell0 step", step_o, 64'd11);
        wait_neg(4);

        // cfg_en_i low mid-run
        set_cfg(64'd0, 64'd100, 64'd3, 32'd2, 2'd0, 16'd0);
        pulse_start();
        wait_neg(6);
        abort(1'b1, 1'b0);
        wait_neg(1);
        chk("en low state", {62'd0, state_o}, 64'd0);
        chk("en low step", step_o, 64'd9);

        // Asynchronous reset mid-run
        set_cfg(64'd0, 64'd1000, 64'd7, 32'd3, 2'd1, 16'd0);
        pulse_start();
        wait_neg(5);
        @(posedge dac_clk_i); #3;
        dac_rst_i = 1'b1;
        exp_q.delete();
        clear_hold();
        #1;
        chk("async rst step", step_o, 64'd0);
        chk("async rst busy", {63'd0, busy_o}, 64'd0);
        chk("async rst state", {62'd0, state_o}, 64'd0);
        @(posedge dac_clk_i); #1 dac_rst_i = 1'b0;
        wait_neg(3);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/asg_sweep_ctrl.md
Name: asg_sweep_ctrl

Overview:
- Frequency-sweep sequencer for one ASG channel.
- Drives the channel's 64-bit phase-pointer step, formed as {set_step_i, set_step_lo_i}, through a programmed linear ramp from a start step to a stop step.
- Holds each step for a programmable dwell, then advances.
- Supports single, repeat and ping-pong sweeps with a sweep counter; sits between the register bank and the channel's step inputs.

Parameters:
- STW, 64, width of step value (hi word = upper 32, lo word = lower 32).
- DWW, 32, width of dwell counter.

Ports:
- dac_clk_i  in  1  DAC clock.
- dac_rst_i  in  1  asynchronous, active-high reset.
- cfg_en_i  in  1  sweep enable; low forces IDLE.
- cfg_start_step_i  in  STW  first step of sweep.
- cfg_stop_step_i  in  STW  last step of sweep.
- cfg_inc_i  in  STW  step increment magnitude per dwell.
- cfg_dwell_i  in  DWW  clock cycles per step; 0 treated as 1.
- cfg_mode_i  in  2  0 single, 1 repeat, 2 ping-pong, 3 = single.
- cfg_nsweep_i  in  16  sweeps before DONE in modes 1/2; 0 = infinite.
- start_i  in  1  start pulse.
- stop_i  in  1  abort pulse.
- step_o  out  STW  step value to ASG channel.
- step_upd_o  out  1  one-cycle pulse when step_o changes/loads.
- sweep_done_o  out  1  one-cycle pulse at end of each sweep.
- busy_o  out  1  high in RUN.
- state_o  out  2  0 IDLE, 1 RUN, 2 DONE.
- sweep_cnt_o  out  16  completed sweeps since start, saturating at 16'hFFFF.

Behaviour:
- Reset values: state IDLE, step_o=0, step_upd_o=0, sweep_done_o=0, busy_o=0, sweep_cnt_o=0, dwell counter=0, direction=up.
- Config inputs are sampled on the start cycle only (start, stop, inc, dwell, mode, nsweep latched); later changes have no effect until the next start.
- Direction is latched at start: up if cfg_start_step_i <= cfg_stop_step_i (unsigned), else down. Target = latched stop.
- IDLE:
  - start_i & cfg_en_i & !stop_i -> RUN next cycle.
  - On that transition: step_o=start, step_upd_o=1, dwell_cnt=max(dwell,1), sweep_cnt_o=0.
  - Latency from start_i to step_o valid is 1 cycle.
- RUN, dwell_cnt>1: decrement; step_o held.
- RUN, dwell_cnt==1 (end of dwell), step_o != target:
  - Compute next = step_o ± inc in STW+1 bits.
  - Up: if next > target or carry, next = target. Down: if borrow or next < target, next = target.
  - step_o <= next; step_upd_o=1; dwell_cnt reloads.
- RUN, end of dwell, step_o == target (sweep end):
  - sweep_done_o=1; sweep_cnt_o+1 (saturating).
  - Mode 0/3: -> DONE, step_o held.
  - Mode 1/2 with nsweep!=0 and new count==nsweep: -> DONE.
  - Otherwise mode 1: step_o=latched start, step_upd_o=1, dwell reload.
  - Otherwise mode 2: swap target (start<->stop), invert direction, step_o=clamped step toward new target, step_upd_o=1.
- A single-point sweep (start==stop) ends at the first end of dwell.
- cfg_inc_i==0 with start!=stop: step_o never changes and the sweep never ends; only stop_i or cfg_en_i low exit.
- DONE:
  - busy_o=0; step_o held.
  - start_i & cfg_en_i -> restart exactly as from IDLE.
  - stop_i or !cfg_en_i -> IDLE.
- stop_i or !cfg_en_i in any state -> IDLE next cycle. step_o holds its last value; no step_upd_o, no sweep_done_o.
- stop_i wins over simultaneous start_i and over a coincident sweep end.
- Asynchronous reset mid-sweep returns all outputs to reset values immediately.
- busy_o = (state==RUN), registered with state.

Test Plan:
- Up sweep: start=100, stop=130, inc=10, dwell=4, mode 0 -> step_o 100,110,120,130 at cycles N+1, +5, +9, +13. One sweep_done_o at N+17, then DONE with step_o=130.
- Clamp/down: start=50, stop=5, inc=20, dwell=1 -> step_o 50,30,10,5, then sweep_done_o; no underflow.
- Ping-pong: start=0, stop=2, inc=1, dwell=1, nsweep=3 -> step_o 0,1,2,1,0,1,2; three sweep_done_o pulses; DONE; sweep_cnt_o=3.
- Repeat infinite: mode 1, nsweep=0, start=0, stop=1, inc=1, dwell=2, run 20 cycles -> sequence 0,1,0,1…; never DONE; stop_i -> IDLE next cycle with step_o held.
- Overflow: start=64'hFFFF_FFFF_FFFF_FFF0, stop=64'hFFFF_FFFF_FFFF_FFFF, inc=64'h20 -> step_o clamps to stop on the first advance; no wrap to a small value.
- Corner cases:
  - start_i and stop_i in the same cycle -> stays IDLE.
  - Reset asserted mid-RUN -> outputs zero immediately.
  - dwell=0 behaves as dwell=1.
